hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard controller for the 5-stage core. It drives the decode/execute register's
//  CLR (FLUSH_E) and its hold (STALL_E), and selects execute-stage operand forwarding.
//  It detects load-use hazards and sequences stalls for multi-cycle execute ops through a small FSM.
//  Sits beside the datapath and consumes register addresses and control bits from the D, E, M and W stages.
// PARAMETERS
//  MC_CYCLES  4   cycles a multi-cycle op occupies E (>=2); stall length = MC_CYCLES-1
//  PERF_W     16  width of the perf counters (HAZARD_PERF_EN only)
// PORTS
//  CLK            in   1       clock; all state updates on the rising edge
//  RST_N          in   1       asynchronous active-low reset
//  RA1_D, RA2_D   in   5       source register addresses in D
//  RA1_E, RA2_E   in   5       source register addresses in E
//  WA_E           in   5       destination register in E (after REG_DST mux)
//  MEM_TO_REG_E   in   1       E instruction is a load
//  MC_OP_E        in   1       E instruction is a multi-cycle op
//  WA_M, WA_W     in   5       destination registers in M and W
//  REG_WRITE_M    in   1       M instruction writes the register file
//  REG_WRITE_W    in   1       W instruction writes the register file
//  STALL_F        out  1       hold the PC
//  STALL_D        out  1       hold the F/D register
//  STALL_E        out  1       hold the D/E register
//  FLUSH_E        out  1       bubble into D/E (drives pipe CLR)
//  FLUSH_M        out  1       bubble into E/M
//  FORWARD_A_E    out  2       source A select: 00 regfile, 01 W result, 10 M ALU result
//  FORWARD_B_E    out  2       source B select, same encoding as FORWARD_A_E
// BEHAVIOUR
//  - Outputs are combinational from inputs and state.
//  - While RST_N=0, every output is 0, the FSM is IDLE and cnt is 0. Reset takes effect immediately, even mid-op.
//  - Forwarding for source A:
//    - 10 if REG_WRITE_M and WA_M!=0 and WA_M==RA1_E;
//    - else 01 if REG_WRITE_W and WA_W!=0 and WA_W==RA1_E;
//    - else 00.
//    - M has priority over W. Source B is identical, using RA2_E.
//  - Load-use (lu): MEM_TO_REG_E and WA_E!=0 and (WA_E==RA1_D or WA_E==RA2_D).
//    When lu is active: STALL_F=STALL_D=FLUSH_E=1 for that cycle. No state is kept.
//  - FSM states IDLE, BUSY, DONE; cnt is $clog2(MC_CYCLES) bits wide.
//  - IDLE:
//    - MC_OP_E=1 makes mc_stall active this cycle.
//    - Next state is DONE if MC_CYCLES==2; otherwise BUSY with cnt=MC_CYCLES-2.
//  - BUSY: mc_stall active. If cnt==1 go to DONE, else cnt decrements.
//  - DONE:
//    - mc_stall inactive and the op advances. MC_OP_E is ignored because it is the same op.
//    - Next state is always IDLE.
//  - mc_stall drives STALL_F=STALL_D=STALL_E=1 and FLUSH_M=1.
//  - mc_stall overrides lu: FLUSH_E=0 while mc_stall is active. lu is re-evaluated once E releases.
//  - The multi-cycle unit captures its operands in the IDLE detect cycle. Forwarding stays live every cycle.
//  - Back-to-back MC ops: the DONE->IDLE pass lets the next op be detected on the following cycle.
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//   - Adds outputs LU_STALL_CNT and MC_STALL_CNT, each [PERF_W-1:0].
//   - Each counter increments once per lu cycle or mc_stall cycle respectively.
//   - Counters saturate at all-ones and clear to 0 on reset.
//  HAZARD_PERF_EN undefined: the ports and counters do not exist; all other behaviour is identical.
// TESTING
//  1. RST_N=0 with MC_OP_E=1 and an lu match -> all outputs 0. Release reset -> FSM starts in IDLE.
//  2. Forwarding priority:
//     - WA_M=5, REG_WRITE_M=1, WA_W=5, REG_WRITE_W=1, RA1_E=5 -> FORWARD_A_E=10.
//     - Drop REG_WRITE_M -> 01.
//     - Set WA_M=WA_W=RA1_E=0 -> 00.
//  3. Load-use:
//     - MEM_TO_REG_E=1, WA_E=7, RA2_D=7 -> STALL_F=STALL_D=FLUSH_E=1, STALL_E=0.
//     - Same with WA_E=0 -> all 0.
//  4. MC_CYCLES=4, MC_OP_E held at 1:
//     - Stalls and FLUSH_M are 1 for exactly 3 cycles (IDLE, BUSY, BUSY), then 0 in DONE.
//     - A new MC op is detected on the next cycle.
//  5. MC_OP_E=1 together with an lu match -> STALL_E=1, FLUSH_M=1, FLUSH_E=0.
//     After release, lu asserts FLUSH_E if the match persists.
//  6. RST_N pulsed low in BUSY -> outputs drop asynchronously and the FSM returns to IDLE.
//     With HAZARD_PERF_EN: after test 4, MC_STALL_CNT=3; a forced count saturates at 16'hFFFF.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard controller for the 5-stage core
// Detects load-use hazards, sequences stalls for multi-cycle execute ops and
// selects execute-stage operand forwarding. Outputs are combinational from
// inputs and state; all outputs are forced to 0 while rst_n is low.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   ra1_d, ra2_d               source registers in D
//   ra1_e, ra2_e, wa_e         source/destination registers in E
//   mem_to_reg_e, mc_op_e      E is a load / E is a multi-cycle op
//   wa_m, wa_w                 destination registers in M and W
//   reg_write_m, reg_write_w   M / W write the register file
//   stall_f, stall_d, stall_e  hold PC, F/D and D/E registers
//   flush_e, flush_m           bubble into D/E and E/M
//   forward_a_e, forward_b_e   operand select: 00 regfile, 01 W, 10 M
//   lu_stall_cnt, mc_stall_cnt saturating perf counters (HAZARD_PERF_EN only)
module hazard_unit #(
    parameter int MC_CYCLES = 4,
    parameter int PERF_W    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1_d,
    input  logic [4:0]  ra2_d,
    input  logic [4:0]  ra1_e,
    input  logic [4:0]  ra2_e,
    input  logic [4:0]  wa_e,
    input  logic        mem_to_reg_e,
    input  logic        mc_op_e,
    input  logic [4:0]  wa_m,
    input  logic [4:0]  wa_w,
    input  logic        reg_write_m,
    input  logic        reg_write_w,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_e,
    output logic        flush_e,
    output logic        flush_m,
    output logic [1:0]  forward_a_e,
    output logic [1:0]  forward_b_e
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] lu_stall_cnt,
    output logic [PERF_W-1:0] mc_stall_cnt
`endif
);
    localparam int CW = $clog2(MC_CYCLES);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lu, mc_stall;

    function automatic logic [1:0] fwd(input logic [4:0] ra);
        return (reg_write_m && wa_m != 5'd0 && wa_m == ra) ? 2'b10 :
               (reg_write_w && wa_w != 5'd0 && wa_w == ra) ? 2'b01 : 2'b00;
    endfunction

    always_comb begin
        lu       = rst_n && mem_to_reg_e && wa_e != 5'd0 && (wa_e == ra1_d || wa_e == ra2_d);
        // DONE ignores mc_op_e: it is still the op that just finished
        mc_stall = rst_n && ((state_q == IDLE && mc_op_e) || state_q == BUSY);
        state_d  = state_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: if (mc_op_e) begin
                state_d = (MC_CYCLES == 2) ? DONE : BUSY;
                cnt_d   = CW'(MC_CYCLES - 2);
            end
            BUSY: if (cnt_q == CW'(1)) state_d = DONE;
                  else cnt_d = cnt_q - CW'(1);
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        stall_f     = lu || mc_stall;
        stall_d     = lu || mc_stall;
        stall_e     = mc_stall;
        // E is held during a multi-cycle op, so a load-use bubble must wait
        flush_e     = lu && !mc_stall;
        flush_m     = mc_stall;
        forward_a_e = rst_n ? fwd(ra1_e) : 2'b00;
        forward_b_e = rst_n ? fwd(ra2_e) : 2'b00;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] lu_cnt_q, lu_cnt_d, mc_cnt_q, mc_cnt_d;

    always_comb begin
        lu_cnt_d = (lu && !(&lu_cnt_q)) ? lu_cnt_q + PERF_W'(1) : lu_cnt_q;
        mc_cnt_d = (mc_stall && !(&mc_cnt_q)) ? mc_cnt_q + PERF_W'(1) : mc_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_cnt_q <= '0;
            mc_cnt_q <= '0;
        end else begin
            lu_cnt_q <= lu_cnt_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    assign lu_stall_cnt = lu_cnt_q;
    assign mc_stall_cnt = mc_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed and randomized check of hazard_unit against a behavioural model
module tb_hazard_unit;
    localparam int MC = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [4:0] ra1_d, ra2_d, ra1_e, ra2_e, wa_e, wa_m, wa_w;
    logic       mem_to_reg_e, mc_op_e, reg_write_m, reg_write_w;
    logic       stall_f, stall_d, stall_e, flush_e, flush_m;
    logic [1:0] forward_a_e, forward_b_e;
    logic [8:0] dut_out;
`ifdef HAZARD_PERF_EN
    logic [15:0] lu_stall_cnt, mc_stall_cnt;
`endif

    int vectors = 0, miscompares = 0;
    int elapsed = 0;
    int lu_n = 0, mc_n = 0;

    hazard_unit #(.MC_CYCLES(MC), .PERF_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .ra1_d(ra1_d), .ra2_d(ra2_d), .ra1_e(ra1_e), .ra2_e(ra2_e), .wa_e(wa_e),
        .mem_to_reg_e(mem_to_reg_e), .mc_op_e(mc_op_e),
        .wa_m(wa_m), .wa_w(wa_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .flush_e(flush_e), .flush_m(flush_m),
        .forward_a_e(forward_a_e), .forward_b_e(forward_b_e)
`ifdef HAZARD_PERF_EN
        , .lu_stall_cnt(lu_stall_cnt), .mc_stall_cnt(mc_stall_cnt)
`endif
    );

    always #5 clk = ~clk;
    assign dut_out = {stall_f, stall_d, stall_e, flush_e, flush_m, forward_a_e, forward_b_e};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] ra);
        if (reg_write_m && wa_m != 0 && wa_m == ra) return 2'b10;
        if (reg_write_w && wa_w != 0 && wa_w == ra) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic ref_lu();
        return rst_n && mem_to_reg_e && wa_e != 0 && (wa_e == ra1_d || wa_e == ra2_d);
    endfunction

    // elapsed = cycles of the current op already spent in E; op lasts MC cycles, last one unstalled
    function automatic logic ref_mc();
        if (!rst_n) return 1'b0;
        return (elapsed == 0) ? mc_op_e : (elapsed + 1 < MC);
    endfunction

    function automatic logic [8:0] ref_out();
        logic l, m;
        l = ref_lu();
        m = ref_mc();
        if (!rst_n) return 9'd0;
        return {l || m, l || m, m, l && !m, m, ref_fwd(ra1_e), ref_fwd(ra2_e)};
    endfunction

    task automatic step();
        logic l, m;
        l = ref_lu();
        m = ref_mc();
        @(posedge clk);
        if (!rst_n) begin
            elapsed = 0; lu_n = 0; mc_n = 0;
        end else begin
            lu_n += int'(l);
            mc_n += int'(m);
            if (elapsed == 0) elapsed = mc_op_e ? 1 : 0;
            else if (elapsed + 1 == MC) elapsed = 0;
            else elapsed++;
        end
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        {ra1_d, ra2_d, ra1_e, ra2_e, wa_e, wa_m, wa_w} = '0;
        {mem_to_reg_e, mc_op_e, reg_write_m, reg_write_w} = '0;
    endtask

    initial begin
        clear_inputs();
        // reset with an mc op and a load-use match present
        #1 rst_n = 1'b0;
        mc_op_e = 1'b1; mem_to_reg_e = 1'b1; wa_e = 5'd7; ra2_d = 5'd7;
        reg_write_m = 1'b1; wa_m = 5'd3; ra1_e = 5'd3;
        #1 check("rst_out", 32'(dut_out), 32'd0);
        step();
        check("rst_hold", 32'(dut_out), 32'd0);
        clear_inputs();
        rst_n = 1'b1;
        #1 check("rst_idle", 32'(dut_out), 32'(ref_out()));
        step();
        // forwarding priority
        wa_m = 5'd5; reg_write_m = 1'b1; wa_w = 5'd5; reg_write_w = 1'b1; ra1_e = 5'd5;
        #1 check("fwd_m", 32'(forward_a_e), 32'h2);
        step();
        reg_write_m = 1'b0;
        #1 check("fwd_w", 32'(forward_a_e), 32'h1);
        step();
        reg_write_m = 1'b1; wa_m = 5'd0; wa_w = 5'd0; ra1_e = 5'd0;
        #1 check("fwd_r0", 32'(forward_a_e), 32'h0);
        step();
        ra2_e = 5'd9; wa_w = 5'd9;
        #1 check("fwd_b_w", 32'(forward_b_e), 32'h1);
        step();
        // load-use
        clear_inputs();
        mem_to_reg_e = 1'b1; wa_e = 5'd7; ra2_d = 5'd7;
        #1 check("lu_hit", 32'({stall_f, stall_d, flush_e, stall_e, flush_m}), 32'b11100);
        step();
        wa_e = 5'd0; ra2_d = 5'd0;
        #1 check("lu_r0", 32'(dut_out), 32'd0);
        step();
        // multi-cycle op held: 3 stalled cycles, one released, then the next op
        clear_inputs();
        mc_op_e = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            #1 check($sformatf("mc_hold%0d", i), 32'({stall_f, stall_d, stall_e, flush_m}),
                     (i == 4) ? 32'h0 : 32'hf);
            step();
        end
        // async reset in BUSY
        #1 check("busy_pre", 32'(stall_e), 32'd1);
        #1 rst_n = 1'b0;
        #1 check("async_rst", 32'(dut_out), 32'd0);
        elapsed = 0; lu_n = 0; mc_n = 0;
        step();
        rst_n = 1'b1; mc_op_e = 1'b0;
        #1 check("post_rst_idle", 32'(dut_out), 32'd0);
        step();
        // mc stall overrides load-use, which reappears on release
        mc_op_e = 1'b1; mem_to_reg_e = 1'b1; wa_e = 5'd7; ra1_d = 5'd7;
        #1 check("mc_over_lu", 32'({stall_e, flush_m, flush_e}), 32'b110);
        step();
        for (int i = 2; i <= 4; i++) begin
            #1 check($sformatf("mc_lu%0d", i), 32'(dut_out), 32'(ref_out()));
            if (i == 4) check("lu_after_release", 32'({flush_e, stall_e}), 32'b10);
            step();
        end
        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst_n        = ($urandom_range(0, 63) != 0);
            ra1_d        = 5'($urandom_range(0, 3));
            ra2_d        = 5'($urandom_range(0, 3));
            ra1_e        = 5'($urandom_range(0, 3));
            ra2_e        = 5'($urandom_range(0, 3));
            wa_e         = 5'($urandom_range(0, 3));
            wa_m         = 5'($urandom_range(0, 3));
            wa_w         = 5'($urandom_range(0, 3));
            mem_to_reg_e = 1'($urandom_range(0, 1));
            mc_op_e      = ($urandom_range(0, 3) == 0);
            reg_write_m  = 1'($urandom_range(0, 1));
            reg_write_w  = 1'($urandom_range(0, 1));
            #1 check("rand", 32'(dut_out), 32'(ref_out()));
            if (!rst_n) begin
                elapsed = 0; lu_n = 0; mc_n = 0;
            end
            step();
        end
`ifdef HAZARD_PERF_EN
        rst_n = 1'b1;
        #1 check("lu_cnt", 32'(lu_stall_cnt), 32'(lu_n));
        check("mc_cnt", 32'(mc_stall_cnt), 32'(mc_n));
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
